// File: rtl/mips_mc_sequencer_pkg.sv
// rtl/mips_mc_sequencer_pkg.sv - shared types and encodings for the multi-cycle sequencer
package mips_mc_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
   } aluOp_e;

   typedef enum logic [2:0] {
      CLS_RTYPE, CLS_JR, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_JUMP
   } instrClass_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] MUX4_JUMP   = 2'b00;
   localparam logic [1:0] MUX4_PC4    = 2'b01;
   localparam logic [1:0] MUX4_BRANCH = 2'b10;
   localparam logic [1:0] MUX4_REG    = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;

   // Microcode layout: regw at bit 0, aluop above it; the mux bits sit at
   // ALUOP_W + offset, and the top bit of the word is spare (driven 0).
   localparam int MC_REGW      = 0;
   localparam int MC_ALUOP_LSB = 1;
   localparam int MC_MUX1_OFS  = 1;
   localparam int MC_MUX2_OFS  = 2;
   localparam int MC_MUX3_OFS  = 3;
   localparam int MC_MUX4_OFS  = 4;

endpackage

// File: rtl/mips_mc_sequencer_if.sv
// rtl/mips_mc_sequencer_if.sv - sequencer-to-datapath/memory control bundle
interface mips_mc_sequencer_if #(
   parameter int ALUOP_W  = 4,
   parameter int RETIRE_W = 16
);
   logic [5:0]          iOpcode;
   logic [5:0]          iFunct;
   logic                iZero;
   logic                iMemReady;
   logic                oCS;
   logic                oWE;
   logic                oAddrSel;
   logic                oIRWrite;
   logic                oPCWrite;
   logic [ALUOP_W+6:0]  oMicrocode;
   logic                oHalt;
   logic [1:0]          oErrCause;
   logic [RETIRE_W-1:0] oRetired;

   modport master (
      input  iOpcode, iFunct, iZero, iMemReady,
      output oCS, oWE, oAddrSel, oIRWrite, oPCWrite, oMicrocode, oHalt, oErrCause, oRetired
   );

   modport slave (
      output iOpcode, iFunct, iZero, iMemReady,
      input  oCS, oWE, oAddrSel, oIRWrite, oPCWrite, oMicrocode, oHalt, oErrCause, oRetired
   );
endinterface

// File: rtl/mips_mc_sequencer_decode.sv
// rtl/mips_mc_sequencer_decode.sv - opcode/funct to instruction class and ALU op
module mips_mc_decode
   import mips_mc_pkg::*;
#(
   parameter int ALUOP_W = 4
) (
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   output instrClass_e        cls,
   output logic [ALUOP_W-1:0] aluOp,
   output logic               illegal
);
   aluOp_e op;

   always_comb begin
      op      = ALU_ADD;
      cls     = CLS_RTYPE;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  op = ALU_ADD;
               FN_SUB:  op = ALU_SUB;
               FN_AND:  op = ALU_AND;
               FN_OR:   op = ALU_OR;
               FN_XOR:  op = ALU_XOR;
               FN_SLT:  op = ALU_SLT;
               FN_SLL:  op = ALU_SLL;
               FN_SRL:  op = ALU_SRL;
               FN_JR:   cls = CLS_JR;
               default: illegal = 1'b1;
            endcase
         end
         OP_J:    cls = CLS_JUMP;
         OP_BEQ:  begin cls = CLS_BEQ; op = ALU_SUB; end
         OP_ADDI: begin cls = CLS_IMM; op = ALU_ADD; end
         OP_ANDI: begin cls = CLS_IMM; op = ALU_AND; end
         OP_ORI:  begin cls = CLS_IMM; op = ALU_OR;  end
         OP_LW:   cls = CLS_LOAD;
         OP_SW:   cls = CLS_STORE;
         default: illegal = 1'b1;
      endcase
   end

   assign aluOp = ALUOP_W'(op);
endmodule

// File: rtl/mips_mc_sequencer.sv
// rtl/mips_mc_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module mips_mc_sequencer
   import mips_mc_pkg::*;
#(
   parameter int ALUOP_W  = 4,
   parameter int TIMEOUT  = 15,
   parameter int RETIRE_W = 16
) (
   input logic                 CLK,
   input logic                 RST,
   mips_mc_sequencer_if.master bus
);
   localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int B_MUX1 = ALUOP_W + MC_MUX1_OFS;
   localparam int B_MUX2 = ALUOP_W + MC_MUX2_OFS;
   localparam int B_MUX3 = ALUOP_W + MC_MUX3_OFS;
   localparam int B_MUX4 = ALUOP_W + MC_MUX4_OFS;

   state_e              state, nextState;
   logic [WCNT_W-1:0]   waitCnt;
   logic [1:0]          errCause, nextCause;
   logic [RETIRE_W-1:0] retired;
   instrClass_e         decCls;
   logic [ALUOP_W-1:0]  decAlu;
   logic                decIllegal;
   logic                timedOut;
   logic                cs, we, addrSel, irWrite, pcWrite;
   logic [ALUOP_W+6:0]  mc;

   mips_mc_decode #(.ALUOP_W(ALUOP_W)) uDecode (
      .opcode  (bus.iOpcode),
      .funct   (bus.iFunct),
      .cls     (decCls),
      .aluOp   (decAlu),
      .illegal (decIllegal)
   );

   assign timedOut = (TIMEOUT != 0) && (waitCnt == WCNT_W'(TIMEOUT)) && !bus.iMemReady;

   always_comb begin
      nextState = state;
      nextCause = errCause;
      cs        = 1'b0;
      we        = 1'b0;
      addrSel   = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      mc        = '0;
      case (state)
         S_IDLE: nextState = S_FETCH;
         S_FETCH: begin
            cs = 1'b1;
            if (bus.iMemReady) begin
               irWrite = 1'b1;
               pcWrite = 1'b1;
               mc[B_MUX4 +: 2] = MUX4_PC4;
               nextState = S_DECODE;
            end else if (timedOut) begin
               nextState = S_ERROR;
               nextCause = ERR_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (decIllegal) begin
               nextState = S_ERROR;
               nextCause = ERR_ILLEGAL;
            end else if (decCls == CLS_JUMP) begin
               pcWrite = 1'b1;
               mc[B_MUX4 +: 2] = MUX4_JUMP;
               nextState = S_FETCH;
            end else begin
               nextState = S_EXEC;
            end
         end
         S_EXEC: begin
            mc[MC_ALUOP_LSB +: ALUOP_W] = decAlu;
            case (decCls)
               CLS_RTYPE: nextState = S_WB;
               CLS_JR: begin
                  pcWrite = 1'b1;
                  mc[B_MUX4 +: 2] = MUX4_REG;
                  nextState = S_FETCH;
               end
               CLS_IMM: begin
                  mc[B_MUX2] = 1'b1;
                  nextState = S_WB;
               end
               CLS_LOAD, CLS_STORE: begin
                  mc[B_MUX2] = 1'b1;
                  nextState = S_MEM;
               end
               CLS_BEQ: begin
                  pcWrite = bus.iZero;
                  mc[B_MUX4 +: 2] = MUX4_BRANCH;
                  nextState = S_FETCH;
               end
               default: nextState = S_FETCH;
            endcase
         end
         S_MEM: begin
            // The ALU result is the live address, so its operands stay selected.
            cs      = 1'b1;
            addrSel = 1'b1;
            we      = (decCls == CLS_STORE);
            mc[MC_ALUOP_LSB +: ALUOP_W] = decAlu;
            mc[B_MUX2] = 1'b1;
            if (bus.iMemReady) begin
               nextState = (decCls == CLS_STORE) ? S_FETCH : S_WB;
            end else if (timedOut) begin
               nextState = S_ERROR;
               nextCause = ERR_TIMEOUT;
            end
         end
         S_WB: begin
            // No ALU output register: the ALU keeps computing the written value.
            mc[MC_REGW] = 1'b1;
            mc[MC_ALUOP_LSB +: ALUOP_W] = decAlu;
            mc[B_MUX2] = (decCls != CLS_RTYPE);
            mc[B_MUX3] = (decCls != CLS_LOAD);
            mc[B_MUX1] = (decCls == CLS_RTYPE);
            nextState = S_FETCH;
         end
         S_ERROR: nextState = S_ERROR;
         default: nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= S_IDLE;
         errCause <= ERR_NONE;
         waitCnt  <= '0;
         retired  <= '0;
      end else begin
         state    <= nextState;
         errCause <= nextCause;
         if (nextState != state) begin
            waitCnt <= '0;
         end else if ((TIMEOUT != 0) && (state == S_FETCH || state == S_MEM) && !bus.iMemReady) begin
            waitCnt <= waitCnt + 1'b1;
         end
         if (nextState == S_FETCH && (state inside {S_DECODE, S_EXEC, S_MEM, S_WB})) begin
            retired <= retired + 1'b1;
         end
      end
   end

   assign bus.oCS        = cs;
   assign bus.oWE        = we;
   assign bus.oAddrSel   = addrSel;
   assign bus.oIRWrite   = irWrite;
   assign bus.oPCWrite   = pcWrite;
   assign bus.oMicrocode = mc;
   assign bus.oHalt      = (state == S_ERROR);
   assign bus.oErrCause  = errCause;
   assign bus.oRetired   = retired;
endmodule

// File: tb/tb_mips_mc_sequencer.sv
// tb/tb_mips_mc_sequencer.sv - scoreboard bench for the multi-cycle sequencer
module tb_mips_mc_sequencer;
   logic CLK = 1'b0;
   logic RST = 1'b0;

   mips_mc_sequencer_if #(.ALUOP_W(4), .RETIRE_W(4)) bus ();

   mips_mc_sequencer #(.ALUOP_W(4), .TIMEOUT(15), .RETIRE_W(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [22:0] v;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  ret;
   logic [18:0] Z, FW, FR, JD, ERRT, ERRI;

   // {cs,we,addrSel,irWrite,pcWrite, spare,mux4,mux3,mux2,mux1,aluop,regw, halt,cause}
   function automatic logic [18:0] ex(input logic cs, we, as, ir, pc, input logic [1:0] m4,
                                      input logic m3, m2, m1, input logic [3:0] alu,
                                      input logic rw, halt, input logic [1:0] cause);
      return {cs, we, as, ir, pc, 1'b0, m4, m3, m2, m1, alu, rw, halt, cause};
   endfunction

   task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input logic [18:0] e);
      bus.iOpcode   = op;
      bus.iFunct    = fn;
      bus.iZero     = z;
      bus.iMemReady = rdy;
      sb.push_back('{name: nm, v: {e, ret}});
      @(posedge CLK);
      #1;
   endtask

   task automatic doReset();
      RST = 1'b0;
      ret = 4'd0;
      cyc("reset", 6'h00, 6'h00, 1'b0, 1'b0, Z);
      RST = 1'b1;
      cyc("idle", 6'h00, 6'h00, 1'b0, 1'b0, Z);
   endtask

   always @(negedge CLK) begin : monitor
      exp_t        x;
      logic [22:0] act;
      act = {bus.oCS, bus.oWE, bus.oAddrSel, bus.oIRWrite, bus.oPCWrite, bus.oMicrocode,
             bus.oHalt, bus.oErrCause, bus.oRetired};
      if (sb.size() > 0) begin
         x = sb.pop_front();
         checks++;
         if (act !== x.v) begin
            errors++;
            $display("FAIL %s: actual %h required %h", x.name, act, x.v);
         end
      end
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: bench did not finish, actual running required done");
      $fatal(1);
   end

   initial begin : stim
      bus.iOpcode = 6'h00; bus.iFunct = 6'h00; bus.iZero = 1'b0; bus.iMemReady = 1'b0;
      ret  = 4'd0;
      Z    = '0;
      FW   = ex(1,0,0,0,0,2'b00,0,0,0,4'd0,0,0,2'b00);
      FR   = ex(1,0,0,1,1,2'b01,0,0,0,4'd0,0,0,2'b00);
      JD   = ex(0,0,0,0,1,2'b00,0,0,0,4'd0,0,0,2'b00);
      ERRT = ex(0,0,0,0,0,2'b00,0,0,0,4'd0,0,1,2'b01);
      ERRI = ex(0,0,0,0,0,2'b00,0,0,0,4'd0,0,1,2'b10);
      repeat (2) @(posedge CLK);
      #1;
      doReset();

      cyc("add fetch",  6'h00, 6'h20, 0, 1, FR);
      cyc("add decode", 6'h00, 6'h20, 0, 1, Z);
      cyc("add exec",   6'h00, 6'h20, 0, 1, Z);
      cyc("add wb",     6'h00, 6'h20, 0, 1, ex(0,0,0,0,0,2'b00,1,0,1,4'd0,1,0,2'b00));
      ret++;

      cyc("sub fetch",  6'h00, 6'h22, 0, 1, FR);
      cyc("sub decode", 6'h00, 6'h22, 0, 1, Z);
      cyc("sub exec",   6'h00, 6'h22, 0, 1, ex(0,0,0,0,0,2'b00,0,0,0,4'd1,0,0,2'b00));
      cyc("sub wb",     6'h00, 6'h22, 0, 1, ex(0,0,0,0,0,2'b00,1,0,1,4'd1,1,0,2'b00));
      ret++;

      cyc("ori fetch",  6'h0D, 6'h00, 0, 1, FR);
      cyc("ori decode", 6'h0D, 6'h00, 0, 1, Z);
      cyc("ori exec",   6'h0D, 6'h00, 0, 1, ex(0,0,0,0,0,2'b00,0,1,0,4'd3,0,0,2'b00));
      cyc("ori wb",     6'h0D, 6'h00, 0, 1, ex(0,0,0,0,0,2'b00,1,1,0,4'd3,1,0,2'b00));
      ret++;

      cyc("jr fetch",  6'h00, 6'h08, 0, 1, FR);
      cyc("jr decode", 6'h00, 6'h08, 0, 1, Z);
      cyc("jr exec",   6'h00, 6'h08, 0, 1, ex(0,0,0,0,1,2'b11,0,0,0,4'd0,0,0,2'b00));
      ret++;

      cyc("lw fetch",  6'h23, 6'h00, 0, 1, FR);
      cyc("lw decode", 6'h23, 6'h00, 0, 1, Z);
      cyc("lw exec",   6'h23, 6'h00, 0, 1, ex(0,0,0,0,0,2'b00,0,1,0,4'd0,0,0,2'b00));
      for (int i = 0; i < 3; i++)
         cyc("lw mem wait", 6'h23, 6'h00, 0, 0, ex(1,0,1,0,0,2'b00,0,1,0,4'd0,0,0,2'b00));
      cyc("lw mem ready", 6'h23, 6'h00, 0, 1, ex(1,0,1,0,0,2'b00,0,1,0,4'd0,0,0,2'b00));
      cyc("lw wb",        6'h23, 6'h00, 0, 1, ex(0,0,0,0,0,2'b00,0,1,0,4'd0,1,0,2'b00));
      ret++;

      cyc("sw fetch",  6'h2B, 6'h00, 0, 1, FR);
      cyc("sw decode", 6'h2B, 6'h00, 0, 1, Z);
      cyc("sw exec",   6'h2B, 6'h00, 0, 1, ex(0,0,0,0,0,2'b00,0,1,0,4'd0,0,0,2'b00));
      cyc("sw mem",    6'h2B, 6'h00, 0, 1, ex(1,1,1,0,0,2'b00,0,1,0,4'd0,0,0,2'b00));
      ret++;

      cyc("beq1 fetch",  6'h04, 6'h00, 1, 1, FR);
      cyc("beq1 decode", 6'h04, 6'h00, 1, 1, Z);
      cyc("beq1 exec",   6'h04, 6'h00, 1, 1, ex(0,0,0,0,1,2'b10,0,0,0,4'd1,0,0,2'b00));
      ret++;
      cyc("beq0 fetch",  6'h04, 6'h00, 0, 1, FR);
      cyc("beq0 decode", 6'h04, 6'h00, 0, 1, Z);
      cyc("beq0 exec",   6'h04, 6'h00, 0, 1, ex(0,0,0,0,0,2'b10,0,0,0,4'd1,0,0,2'b00));
      ret++;

      cyc("j fetch",  6'h02, 6'h00, 0, 1, FR);
      cyc("j decode", 6'h02, 6'h00, 0, 1, JD);
      ret++;

      for (int i = 0; i < 16; i++)
         cyc("timeout wait", 6'h02, 6'h00, 0, 0, FW);
      cyc("timeout error",  6'h02, 6'h00, 0, 1, ERRT);
      cyc("timeout held",   6'h02, 6'h00, 0, 1, ERRT);

      doReset();
      for (int i = 0; i < 15; i++)
         cyc("late wait", 6'h02, 6'h00, 0, 0, FW);
      cyc("late ready",  6'h02, 6'h00, 0, 1, FR);
      cyc("late decode", 6'h02, 6'h00, 0, 1, JD);
      ret++;

      cyc("illegal fetch",  6'h3F, 6'h00, 0, 1, FR);
      cyc("illegal decode", 6'h3F, 6'h00, 0, 1, Z);
      cyc("illegal error",  6'h3F, 6'h00, 0, 1, ERRI);
      cyc("illegal held",   6'h3F, 6'h00, 0, 0, ERRI);

      doReset();
      cyc("pre j fetch",  6'h02, 6'h00, 0, 1, FR);
      cyc("pre j decode", 6'h02, 6'h00, 0, 1, JD);
      ret++;
      cyc("rst sw fetch",  6'h2B, 6'h00, 0, 1, FR);
      cyc("rst sw decode", 6'h2B, 6'h00, 0, 1, Z);
      cyc("rst sw exec",   6'h2B, 6'h00, 0, 1, ex(0,0,0,0,0,2'b00,0,1,0,4'd0,0,0,2'b00));
      cyc("rst sw mem",    6'h2B, 6'h00, 0, 0, ex(1,1,1,0,0,2'b00,0,1,0,4'd0,0,0,2'b00));
      doReset();

      for (int i = 0; i < 16; i++) begin
         cyc("wrap j fetch",  6'h02, 6'h00, 0, 1, FR);
         cyc("wrap j decode", 6'h02, 6'h00, 0, 1, JD);
         ret++;
      end
      cyc("wrapped", 6'h02, 6'h00, 0, 0, FW);

      @(negedge CLK);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: actual %0d pending required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
